// File: rtl/apb_pkg.sv
`default_nettype none
// apb_pkg: shared FSM encoding, APB address constants and select-vector helper
// for the APB slave bank.  Rev 1.0
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Word addresses start at this byte-address bit.
  localparam int BYTE_OFF = 2;
  localparam int MAX_SLV  = 32;

  function automatic logic is_onehot(input logic [MAX_SLV-1:0] v);
    return $countones(v) == 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_bank_if.sv
`default_nettype none
// apb_slave_bank_if: APB completer-side bus bundle with master/slave views.
// Rev 1.0
interface apb_slave_bank_if #(
  parameter int NUM_SLV = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
);
  logic [NUM_SLV-1:0] psel;
  logic               penable;
  logic               pwrite;
  logic [ADDR_W-1:0]  paddr;
  logic [DATA_W-1:0]  pwdata;
  logic [DATA_W-1:0]  prdata;
  logic               pready;
  logic               pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_regfile.sv
`default_nettype none
// apb_regfile: DEPTH x DATA_W register storage, one write port, combinational
// read, asynchronous reset to RST_VAL.  Rev 1.0
module apb_regfile #(
  parameter int                DEPTH   = 16,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int               IDX_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[idx];

endmodule
`default_nettype wire

// File: rtl/apb_slave_bank.sv
`default_nettype none
// apb_slave_bank: NUM_SLV APB register-file slaves behind one access FSM with
// programmable wait states and address/select error reporting.  Rev 1.0
module apb_slave_bank
  import apb_pkg::*;
#(
  parameter int                NUM_SLV  = 3,
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 16,
  parameter int                WAIT_CYC = 2,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic             Hclk,
  input  logic             Hresetn,
  apb_slave_bank_if.slave  apb
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               any_sel;
  logic               err;
  logic               complete;
  logic               ready;
  logic               slverr;
  logic [NUM_SLV-1:0] we;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  rd [NUM_SLV];
  logic [DATA_W-1:0]  rd_mux;

  assign any_sel = |apb.psel;
  assign idx     = apb.paddr[IDX_W+BYTE_OFF-1:BYTE_OFF];

  // Only meaningful on the completing cycle of an access phase.
  assign err = !is_onehot(MAX_SLV'(apb.psel))
            || (apb.psel != sel_q)
            || (apb.paddr != addr_q)
            || (apb.paddr[BYTE_OFF-1:0] != '0)
            || (apb.paddr[ADDR_W-1:IDX_W+BYTE_OFF] != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    ready    = 1'b0;
    slverr   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_sel && !apb.penable) begin
          sel_d   = apb.psel;
          addr_d  = apb.paddr;
          cnt_d   = CNT_W'(WAIT_CYC);
          state_d = ST_ACCESS;
        end else if (any_sel && apb.penable) begin
          ready  = 1'b1;
          slverr = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!any_sel) begin
          state_d = ST_IDLE;
        end else if (!apb.penable) begin
          // A fresh setup before completion restarts the transfer.
          sel_d  = apb.psel;
          addr_d = apb.paddr;
          cnt_d  = CNT_W'(WAIT_CYC);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ready    = 1'b1;
          slverr   = err;
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
    end
  end

  generate
    for (genvar k = 0; k < NUM_SLV; k++) begin : g_slv
      assign we[k] = complete && apb.pwrite && !err && apb.psel[k];

      apb_regfile #(
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
      ) u_regfile (
        .clk   (Hclk),
        .rst_n (Hresetn),
        .we    (we[k]),
        .idx   (idx),
        .wdata (apb.pwdata),
        .rdata (rd[k])
      );
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (apb.psel[k]) rd_mux = rd_mux | rd[k];
    end
  end

  assign apb.prdata  = (complete && !apb.pwrite && !err) ? rd_mux : '0;
  // Keeps a held bus from raising a violation response while in reset.
  assign apb.pready  = Hresetn && ready;
  assign apb.pslverr = Hresetn && slverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_bank.sv
`default_nettype none
// tb_apb_slave_bank: randomized APB traffic on a WAIT_CYC=2 and a WAIT_CYC=0
// instance, checked every cycle against a transaction-level memory model.
module tb_apb_slave_bank;

  localparam int NS    = 3;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int IDXW  = 4;

  logic Hclk    = 1'b0;
  logic Hresetn = 1'b1;
  always #5 Hclk = ~Hclk;

  apb_slave_bank_if #(.NUM_SLV(NS), .DATA_W(DW), .ADDR_W(AW)) bus_a ();
  apb_slave_bank_if #(.NUM_SLV(NS), .DATA_W(DW), .ADDR_W(AW)) bus_b ();

  apb_slave_bank #(
    .NUM_SLV(NS), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(2), .RST_VAL('0)
  ) dut_a (
    .Hclk(Hclk), .Hresetn(Hresetn), .apb(bus_a.slave)
  );

  apb_slave_bank #(
    .NUM_SLV(NS), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(0), .RST_VAL('0)
  ) dut_b (
    .Hclk(Hclk), .Hresetn(Hresetn), .apb(bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [2][NS][DEPTH];
  logic        exp_rdy  [2] = '{1'b0, 1'b0};
  logic        exp_err  [2] = '{1'b0, 1'b0};
  logic [31:0] exp_data [2] = '{32'h0, 32'h0};

  logic [31:0] obs_rdata;
  logic        obs_err;
  int          obs_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Hclk) begin
    check("pready_a",  {31'b0, bus_a.pready},  {31'b0, exp_rdy[0]});
    check("pslverr_a", {31'b0, bus_a.pslverr}, {31'b0, exp_err[0]});
    check("prdata_a",  bus_a.prdata,           exp_data[0]);
    check("pready_b",  {31'b0, bus_b.pready},  {31'b0, exp_rdy[1]});
    check("pslverr_b", {31'b0, bus_b.pslverr}, {31'b0, exp_err[1]});
    check("prdata_b",  bus_b.prdata,           exp_data[1]);
  end

  function automatic int waits(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic dut_rdy(input int d);
    return (d == 0) ? bus_a.pready : bus_b.pready;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < DEPTH; w++) mem_m[d][s][w] = 32'h0;
  endtask

  task automatic drive(input int d, input logic [2:0] s, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      bus_a.psel = s; bus_a.penable = en; bus_a.pwrite = wr; bus_a.paddr = a; bus_a.pwdata = wd;
    end else begin
      bus_b.psel = s; bus_b.penable = en; bus_b.pwrite = wr; bus_b.paddr = a; bus_b.pwdata = wd;
    end
  endtask

  task automatic set_exp(input int d, input logic r, input logic e, input logic [31:0] v);
    exp_rdy[d] = r; exp_err[d] = e; exp_data[d] = v;
  endtask

  function automatic logic model_err(input logic [2:0] s_set, input logic [31:0] a_set,
                                     input logic [2:0] s_acc, input logic [31:0] a_acc);
    return ($countones(s_acc) != 1) || (s_acc != s_set) || (a_acc != a_set)
        || (a_acc % 4 != 0) || ((a_acc >> (2 + IDXW)) != 0);
  endfunction

  function automatic int slv_of(input logic [2:0] s);
    for (int k = 0; k < NS; k++) if (s[k]) return k;
    return 0;
  endfunction

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Hclk); #1;
      drive(d, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
      set_exp(d, 1'b0, 1'b0, 32'h0);
    end
  endtask

  // One full transfer: setup, WAIT_CYC wait cycles, completing cycle.
  task automatic xfer(input int d, input logic [2:0] s_set, input logic [31:0] a_set,
                      input logic [2:0] s_acc, input logic [31:0] a_acc,
                      input logic wr, input logic [31:0] wd);
    int          w;
    logic        err;
    logic [31:0] ed;
    int          sl;
    int          ix;
    w       = waits(d);
    err     = model_err(s_set, a_set, s_acc, a_acc);
    sl      = slv_of(s_acc);
    ix      = int'((a_acc >> 2) % DEPTH);
    obs_lat = 0;
    @(posedge Hclk); #1;
    drive(d, s_set, 1'b0, wr, a_set, wd);
    set_exp(d, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i <= w; i++) begin
      @(posedge Hclk); #1;
      drive(d, s_acc, 1'b1, wr, a_acc, wd);
      if (i < w) begin
        set_exp(d, 1'b0, 1'b0, 32'h0);
      end else begin
        ed = (!wr && !err) ? mem_m[d][sl][ix] : 32'h0;
        set_exp(d, 1'b1, err, ed);
      end
      @(negedge Hclk);
      if (obs_lat == 0 && dut_rdy(d)) obs_lat = i + 1;
    end
    obs_rdata = (d == 0) ? bus_a.prdata  : bus_b.prdata;
    obs_err   = (d == 0) ? bus_a.pslverr : bus_b.pslverr;
    if (wr && !err) mem_m[d][sl][ix] = wd;
  endtask

  // Setup plus k wait cycles, then either an abort (psel=0) or nothing (restart follows).
  task automatic partial(input int d, input logic [2:0] s, input logic [31:0] a,
                         input logic wr, input logic [31:0] wd, input int k, input logic do_abort);
    @(posedge Hclk); #1;
    drive(d, s, 1'b0, wr, a, wd);
    set_exp(d, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < k; i++) begin
      @(posedge Hclk); #1;
      drive(d, s, 1'b1, wr, a, wd);
      set_exp(d, 1'b0, 1'b0, 32'h0);
    end
    if (do_abort) idle(d, 1);
  endtask

  task automatic viol(input int d);
    @(posedge Hclk); #1;
    drive(d, 3'b001, 1'b1, 1'b0, 32'h0C, 32'h0);
    set_exp(d, 1'b1, 1'b1, 32'h0);
    @(negedge Hclk);
    obs_rdata = (d == 0) ? bus_a.prdata : bus_b.prdata;
    obs_err   = (d == 0) ? bus_a.pslverr : bus_b.pslverr;
    obs_lat   = dut_rdy(d) ? 1 : 0;
    idle(d, 1);
  endtask

  task automatic pin(input string name, input int lat, input logic e, input logic [31:0] v);
    check({name, "_lat"},  32'(obs_lat), 32'(lat));
    check({name, "_err"},  {31'b0, obs_err}, {31'b0, e});
    check({name, "_data"}, obs_rdata, v);
  endtask

  initial begin
    logic [2:0]  s, s2;
    logic [31:0] a, a2, wd;
    logic        wr;
    int          d, kind, k;
    logic [2:0]  multi [4] = '{3'b011, 3'b101, 3'b110, 3'b111};

    clear_model();
    drive(0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 Hresetn = 1'b0;
    repeat (3) @(negedge Hclk);
    check("rst_pready",  {31'b0, bus_a.pready},  32'h0);
    check("rst_pslverr", {31'b0, bus_a.pslverr}, 32'h0);
    check("rst_prdata",  bus_a.prdata,           32'h0);
    Hresetn = 1'b1;

    // Directed traffic on the WAIT_CYC=2 instance.
    xfer(0, 3'b001, 32'h0C, 3'b001, 32'h0C, 1'b0, 32'h0);
    pin("rd_s0w3", 3, 1'b0, 32'h0);
    xfer(0, 3'b010, 32'h14, 3'b010, 32'h14, 1'b1, 32'hDEADBEEF);
    pin("wr_s1w5", 3, 1'b0, 32'h0);
    idle(0, 1);
    xfer(0, 3'b010, 32'h14, 3'b010, 32'h14, 1'b0, 32'h0);
    pin("rd_s1w5", 3, 1'b0, 32'hDEADBEEF);
    xfer(0, 3'b100, 32'h14, 3'b100, 32'h14, 1'b0, 32'h0);
    pin("rd_s2w5", 3, 1'b0, 32'h0);
    xfer(0, 3'b010, 32'h16, 3'b010, 32'h16, 1'b1, 32'h11111111);
    pin("wr_misal", 3, 1'b1, 32'h0);
    xfer(0, 3'b010, 32'h40, 3'b010, 32'h40, 1'b1, 32'h22222222);
    pin("wr_range", 3, 1'b1, 32'h0);
    xfer(0, 3'b011, 32'h14, 3'b011, 32'h14, 1'b1, 32'h55555555);
    pin("wr_multi", 3, 1'b1, 32'h0);
    xfer(0, 3'b011, 32'h14, 3'b011, 32'h14, 1'b0, 32'h0);
    pin("rd_multi", 3, 1'b1, 32'h0);
    xfer(0, 3'b010, 32'h14, 3'b010, 32'h14, 1'b0, 32'h0);
    pin("rd_s1w5_kept", 3, 1'b0, 32'hDEADBEEF);
    xfer(0, 3'b001, 32'h14, 3'b001, 32'h14, 1'b0, 32'h0);
    pin("rd_s0w5_kept", 3, 1'b0, 32'h0);
    viol(0);
    pin("idle_viol", 1, 1'b1, 32'h0);

    // Reset during a wait cycle of a write.
    partial(0, 3'b001, 32'h08, 1'b1, 32'h12345678, 1, 1'b0);
    @(posedge Hclk); #1;
    drive(0, 3'b001, 1'b1, 1'b1, 32'h08, 32'h12345678);
    set_exp(0, 1'b0, 1'b0, 32'h0);
    #2 Hresetn = 1'b0;
    clear_model();
    #1;
    check("mid_rst_pready",  {31'b0, bus_a.pready},  32'h0);
    check("mid_rst_pslverr", {31'b0, bus_a.pslverr}, 32'h0);
    check("mid_rst_prdata",  bus_a.prdata,           32'h0);
    repeat (2) @(negedge Hclk);
    idle(0, 1);
    @(negedge Hclk) Hresetn = 1'b1;
    xfer(0, 3'b001, 32'h08, 3'b001, 32'h08, 1'b0, 32'h0);
    pin("rd_after_rst", 3, 1'b0, 32'h0);
    xfer(0, 3'b010, 32'h14, 3'b010, 32'h14, 1'b0, 32'h0);
    pin("rd_s1w5_rst", 3, 1'b0, 32'h0);
    idle(0, 1);

    // Back-to-back on the WAIT_CYC=0 instance.
    xfer(1, 3'b100, 32'h20, 3'b100, 32'h20, 1'b1, 32'hAAAA5555);
    pin("b2b_wr1", 1, 1'b0, 32'h0);
    xfer(1, 3'b100, 32'h20, 3'b100, 32'h20, 1'b0, 32'h0);
    pin("b2b_rd", 1, 1'b0, 32'hAAAA5555);
    xfer(1, 3'b100, 32'h24, 3'b100, 32'h24, 1'b1, 32'h0F0F0F0F);
    pin("b2b_wr2", 1, 1'b0, 32'h0);
    xfer(1, 3'b100, 32'h24, 3'b100, 32'h24, 1'b0, 32'h0);
    pin("b2b_rd2", 1, 1'b0, 32'h0F0F0F0F);
    idle(1, 1);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 240; n++) begin
      d    = (n < 160) ? 0 : 1;
      kind = int'($urandom_range(0, 15));
      s    = 3'b001 << $urandom_range(0, 2);
      a    = 32'($urandom_range(0, DEPTH - 1)) * 4;
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      s2   = s;
      a2   = a;
      case (kind)
        0: begin a = a | 32'($urandom_range(1, 3)); a2 = a; end
        1: begin a = a | (32'($urandom_range(1, 255)) << (2 + IDXW)); a2 = a; end
        2: begin s = multi[$urandom_range(0, 3)]; s2 = s; end
        3: s2 = ((s << 1) | (s >> 2)) & 3'b111;
        4: a2 = a ^ 32'h4;
        default: ;
      endcase
      if (kind == 5) begin
        k = int'($urandom_range(0, waits(d)));
        partial(d, s, a, wr, wd, k, 1'b1);
      end else if (kind == 6) begin
        k = int'($urandom_range(0, waits(d)));
        partial(d, 3'b001 << $urandom_range(0, 2), 32'($urandom_range(0, 15)) * 4,
                1'($urandom_range(0, 1)), $urandom, k, 1'b0);
        xfer(d, s, a, s2, a2, wr, wd);
      end else if (kind == 7) begin
        viol(d);
      end else begin
        xfer(d, s, a, s2, a2, wr, wd);
      end
      if ($urandom_range(0, 3) == 0) idle(d, 1);
    end
    idle(0, 1);
    idle(1, 1);
    @(negedge Hclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_slave_bank.md
Name: apb_slave_bank

Overview:
- Parametrised APB slave bank that terminates the bridge's APB side for NUM_SLV peripherals. Each peripheral is backed by a real register file of DEPTH words.
- Adds a proper access FSM, programmable wait states (PREADY), address/select error reporting (PSLVERR), and write-back/read-back storage.
- Replaces the fixed-value read stub. Sits directly below the AHB-to-APB bridge in both the top-level testbench and the integration model.

Parameters:
- NUM_SLV, 3: number of psel lines / register files.
- DATA_W, 32: pwdata/prdata width.
- ADDR_W, 32: paddr width.
- DEPTH, 16: words per slave; power of 2, ≥2. IDX_W = log2(DEPTH).
- WAIT_CYC, 2: wait cycles inserted in each access phase; 0..15.
- RST_VAL, 0: reset value of every register word.

Ports:
- Hclk  in  1  clock; all state updates on rising edge.
- Hresetn  in  1  asynchronous active-low reset.
- psel  in  NUM_SLV  one-hot slave select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data; valid only when pready && !pwrite.
- pready  out  1  transfer completion.
- pslverr  out  1  error response; valid only with pready.

Behaviour:
- Interface: one clock (Hclk); reset is asynchronous and active-low (Hresetn).
- Reset (async assert, sync-release usage):
  - FSM goes to IDLE; wait counter = 0.
  - All register words = RST_VAL.
  - prdata = 0, pready = 0, pslverr = 0.
  - Reset mid-transfer aborts the transfer with no write.
- FSM states: IDLE, ACCESS.
- IDLE:
  - A setup phase is psel != 0 && !penable. On it: latch psel into sel_q, latch paddr, load cnt = WAIT_CYC, next state = ACCESS.
  - psel != 0 && penable while in IDLE is a protocol violation: pready = 1 and pslverr = 1 for that cycle, no write, stay IDLE.
- ACCESS, cycle with psel != 0 && penable:
  - cnt != 0: pready = 0, cnt decrements.
  - cnt == 0: pready = 1, the transfer completes, next state = IDLE.
  - Access phase therefore lasts exactly WAIT_CYC+1 cycles.
- ACCESS with psel == 0: abort, return to IDLE, no write, pready = 0.
- ACCESS with penable == 0 (a new setup arriving without completion): treat as a restart. Relatch and reload cnt; stay in ACCESS.
- Error conditions, evaluated on the completing cycle:
  - psel not one-hot;
  - psel != sel_q;
  - paddr != latched address;
  - paddr[1:0] != 0;
  - any paddr bit above 2+IDX_W-1 != 0.
- On error: pslverr = 1, no write, prdata = 0.
- Word index = paddr[IDX_W+1:2].
- Write: on the completing cycle with pwrite && !err, the selected slave's word is written with pwdata. The write is visible to a read whose access phase starts on the next cycle.
- Read: prdata = selected word on the completing cycle, combinational from storage; prdata = 0 on all other cycles.
- pready and pslverr are combinational from state/cnt/inputs. Both are 0 whenever the block is not completing or flagging a violation.
- Back-to-back transfers: a setup in the cycle right after completion is accepted with no idle gap.
- Simultaneous read and write to the same word cannot occur (single APB master).
- Slaves are independent: a write to slave k never alters slave j.

Decomposition:
- Shared package apb_pkg holds:
  - state encoding ST_IDLE / ST_ACCESS;
  - APB byte-offset constant (2);
  - a function returning one-hot validity of a select vector.
- One sub-module, apb_regfile: a DEPTH×DATA_W storage with async-reset to RST_VAL, single write port (we, idx, wdata) and combinational read (idx).
- apb_regfile is instantiated NUM_SLV times via generate. The top contains the FSM, wait counter, decode and muxing.

Test Plan:
- Reset then read slave 0 word 3 (psel=3'b001, paddr=0x0C) → pready high on the 3rd access cycle, prdata=0x00000000, pslverr=0.
- Write 0xDEADBEEF to slave 1 word 5 (psel=3'b010, paddr=0x14), then read back → pready after 2 wait cycles both times, read returns 0xDEADBEEF. Same address in slave 2 still reads 0.
- Misaligned paddr=0x16 or out-of-range paddr=0x40 → pslverr=1 with pready; no word changes (read-back of 0x14 unchanged).
- psel=3'b011 (not one-hot) → pslverr=1 on completion, prdata=0, no write. Also penable=1 in IDLE → single-cycle pready=1, pslverr=1.
- Assert Hresetn=0 during a wait cycle of a write of 0x12345678 → outputs go to 0 immediately, and after reset the word reads RST_VAL.
- Back-to-back write/read/write with WAIT_CYC=0 (separate elaboration) → each transfer takes exactly 2 cycles (setup + access), with correct data each time.
